// File: rtl/line_cycle_pkg.sv
// Shared definitions for the line cycle detector: FSM state encoding and counter widths.
package line_cycle_pkg;

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    LOW       = 3'd1,
    QUAL_HIGH = 3'd2,
    HIGH      = 3'd3,
    QUAL_LOW  = 3'd4
  } state_t;

  localparam int DEB_W        = 8;
  localparam int TO_W_DEFAULT = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both stages clear on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic stage_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_reg  <= 1'b0;
      stage_reg <= 1'b0;
    end else begin
      meta_reg  <= async_in;
      stage_reg <= meta_reg;
    end
  end

  assign sync_out = stage_reg;

endmodule

// File: rtl/line_cycle_detector.sv
// Mains zero-cross qualifier: one pulse per debounced rising edge plus a sticky loss-of-line flag.
// Optional period measurement is built when LINE_PERIOD_MEAS_EN is defined.
module line_cycle_detector
  import line_cycle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int TO_W            = TO_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            enable_i,
  input  logic            line_i,
  input  logic            timeout_clear_i,
  output logic            cycle_pulse_o,
  output logic            line_level_o,
  output logic            timeout_o
`ifdef LINE_PERIOD_MEAS_EN
  ,
  output logic [TO_W-1:0] period_o,
  output logic            period_valid_o
`endif
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  logic             line_s;
  state_t           state_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic [TO_W-1:0]  per_cnt_reg;
  logic [1:0]       warm_reg;
  logic             rise_reg;
  logic             pulse_reg;
  logic             level_reg;
  logic             timeout_reg;

  sync_2ff u_sync (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .async_in (line_i),
    .sync_out (line_s)
  );

  // warm_reg masks the synchroniser's reset zeros so a line already high at
  // reset release cannot look like a fresh low-to-high transition.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= ARM;
      deb_cnt_reg <= '0;
      per_cnt_reg <= '0;
      warm_reg    <= 2'b00;
      rise_reg    <= 1'b0;
      pulse_reg   <= 1'b0;
      level_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      warm_reg  <= {warm_reg[0], 1'b1};
      level_reg <= (state_reg == HIGH) || (state_reg == QUAL_LOW);

      if (timeout_clear_i)
        timeout_reg <= 1'b0;
      else if (enable_i && (per_cnt_reg == TO_MAX))
        timeout_reg <= 1'b1;

      if (!enable_i) begin
        state_reg   <= ARM;
        deb_cnt_reg <= '0;
        per_cnt_reg <= '0;
        rise_reg    <= 1'b0;
        pulse_reg   <= 1'b0;
      end else begin
        pulse_reg <= rise_reg;
        rise_reg  <= 1'b0;

        if (rise_reg)
          per_cnt_reg <= '0;
        else if (per_cnt_reg != TO_MAX)
          per_cnt_reg <= per_cnt_reg + TO_ONE;

        case (state_reg)
          ARM: begin
            if (warm_reg[1] && !line_s)
              state_reg <= LOW;
          end
          LOW: begin
            if (line_s) begin
              state_reg   <= QUAL_HIGH;
              deb_cnt_reg <= DEB_ONE;
            end
          end
          QUAL_HIGH: begin
            if (!line_s) begin
              state_reg   <= LOW;
              deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
              state_reg   <= HIGH;
              deb_cnt_reg <= '0;
              rise_reg    <= 1'b1;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DEB_ONE;
            end
          end
          HIGH: begin
            if (!line_s) begin
              state_reg   <= QUAL_LOW;
              deb_cnt_reg <= DEB_ONE;
            end
          end
          QUAL_LOW: begin
            if (line_s) begin
              state_reg   <= HIGH;
              deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
              state_reg   <= LOW;
              deb_cnt_reg <= '0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DEB_ONE;
            end
          end
          default: begin
            state_reg   <= ARM;
            deb_cnt_reg <= '0;
          end
        endcase
      end
    end
  end

  assign cycle_pulse_o = pulse_reg;
  assign line_level_o  = level_reg;
  assign timeout_o     = timeout_reg;

`ifdef LINE_PERIOD_MEAS_EN
  logic [TO_W:0]   per_inc;
  logic [TO_W-1:0] per_sat;
  logic            seen_reg;
  logic [TO_W-1:0] period_reg;
  logic            period_valid_reg;

  assign per_inc = {1'b0, per_cnt_reg} + {{TO_W{1'b0}}, 1'b1};
  assign per_sat = (per_inc > {1'b0, TO_MAX}) ? TO_MAX : per_inc[TO_W-1:0];

  // The first pulse after arming has no preceding edge, so it only primes seen_reg.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seen_reg         <= 1'b0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
    end else begin
      period_valid_reg <= 1'b0;
      if (!enable_i || (state_reg == ARM)) begin
        seen_reg <= 1'b0;
      end else if (rise_reg) begin
        seen_reg <= 1'b1;
        if (seen_reg) begin
          period_reg       <= per_sat;
          period_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign period_o       = period_reg;
  assign period_valid_o = period_valid_reg;
`endif

endmodule

// File: tb/tb_line_cycle_detector.sv
// Scoreboard bench for line_cycle_detector: two instances (short and long timeout) share stimulus.
module tb_line_cycle_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic line = 1'b0;
  logic clr = 1'b0;

  logic pulse_a, level_a, to_a;
  logic pulse_b, level_b, to_b;

  int cyc = 0;
  int vectors = 0;
  int fails = 0;
  int qa[$];
  int qb[$];
  int ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef LINE_PERIOD_MEAS_EN
  logic [19:0] per_a, per_b;
  logic        pv_a, pv_b;
  typedef struct { int c; int v; } pexp_t;
  pexp_t pqa[$];
  pexp_t pqb[$];
  pexp_t pe;
`endif

  line_cycle_detector #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100), .TO_W(20)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .line_i(line), .timeout_clear_i(clr),
    .cycle_pulse_o(pulse_a), .line_level_o(level_a), .timeout_o(to_a)
`ifdef LINE_PERIOD_MEAS_EN
    , .period_o(per_a), .period_valid_o(pv_a)
`endif
  );

  line_cycle_detector #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000), .TO_W(20)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .line_i(line), .timeout_clear_i(clr),
    .cycle_pulse_o(pulse_b), .line_level_o(level_b), .timeout_o(to_b)
`ifdef LINE_PERIOD_MEAS_EN
    , .period_o(per_b), .period_valid_o(pv_b)
`endif
  );

  // Output monitor: every observed pulse must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (pulse_a === 1'b1) begin
      vectors++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL pulse_a: unexpected pulse at cycle %0d, none required", cyc);
      end else begin
        ea = qa.pop_front();
        if (cyc !== ea) begin
          fails++;
          $display("FAIL pulse_a: pulse at cycle %0d, required at %0d", cyc, ea);
        end
      end
    end
    if (pulse_b === 1'b1) begin
      vectors++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL pulse_b: unexpected pulse at cycle %0d, none required", cyc);
      end else begin
        eb = qb.pop_front();
        if (cyc !== eb) begin
          fails++;
          $display("FAIL pulse_b: pulse at cycle %0d, required at %0d", cyc, eb);
        end
      end
    end
`ifdef LINE_PERIOD_MEAS_EN
    if (pv_a === 1'b1) begin
      vectors++;
      if (pqa.size() == 0) begin
        fails++;
        $display("FAIL period_a: unexpected valid at cycle %0d (period %0d)", cyc, per_a);
      end else begin
        pe = pqa.pop_front();
        if (cyc !== pe.c || int'(per_a) !== pe.v) begin
          fails++;
          $display("FAIL period_a: cycle %0d period %0d, required cycle %0d period %0d", cyc, per_a, pe.c, pe.v);
        end
      end
    end
    if (pv_b === 1'b1) begin
      vectors++;
      if (pqb.size() == 0) begin
        fails++;
        $display("FAIL period_b: unexpected valid at cycle %0d (period %0d)", cyc, per_b);
      end else begin
        pe = pqb.pop_front();
        if (cyc !== pe.c || int'(per_b) !== pe.v) begin
          fails++;
          $display("FAIL period_b: cycle %0d period %0d, required cycle %0d period %0d", cyc, per_b, pe.c, pe.v);
        end
      end
    end
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic expect_pulse(input int c);
    qa.push_back(c);
    qb.push_back(c);
  endtask

  task automatic check_drained(input string name);
    int pend;
    pend = qa.size() + qb.size();
`ifdef LINE_PERIOD_MEAS_EN
    pend += pqa.size() + pqb.size();
`endif
    vectors++;
    if (pend !== 0) begin
      fails++;
      $display("FAIL %s drained: %0d expected events outstanding, required 0", name, pend);
    end
    qa.delete(); qb.delete();
`ifdef LINE_PERIOD_MEAS_EN
    pqa.delete(); pqb.delete();
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; line = 1'b0; clr = 1'b0;
    tick(3);
    @(negedge clk);
    vectors++;
    if ({pulse_a, level_a, to_a, pulse_b, level_b, to_b} !== 6'b0) begin
      fails++;
      $display("FAIL reset outputs: got %b, required 000000", {pulse_a, level_a, to_a, pulse_b, level_b, to_b});
    end
    tick(1);
    rst_n = 1'b1;
    tick(3);
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_clean_edge();
    int k;
    enable = 1'b0; line = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(10);
    k = cyc;
    line = 1'b1;
    expect_pulse(k + 7);
    wait_cyc(k + 6);
    @(negedge clk);
    vectors++;
    if ({level_a, level_b} !== 2'b00) begin
      fails++;
      $display("FAIL clean level early: got %b at cycle %0d, required 00", {level_a, level_b}, cyc);
    end
    wait_cyc(k + 7);
    @(negedge clk);
    vectors++;
    if ({level_a, level_b} !== 2'b11) begin
      fails++;
      $display("FAIL clean level: got %b at cycle %0d, required 11", {level_a, level_b}, cyc);
    end
    tick(20);
    check_drained("clean_edge");
    $display("clean edge: line rise at cycle %0d, pulse expected at %0d", k, k + 7);
  endtask

  task automatic test_glitch();
    int k;
    logic hi_seen;
    enable = 1'b0; line = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(5);
    for (int g = 0; g < 3; g++) begin
      hi_seen = 1'b0;
      line = 1'b1;
      tick(3);
      line = 1'b0;
      for (int j = 0; j < 8; j++) begin
        tick(1);
        if (level_a !== 1'b0 || level_b !== 1'b0) hi_seen = 1'b1;
      end
      vectors++;
      if (hi_seen !== 1'b0) begin
        fails++;
        $display("FAIL glitch %0d level: got high, required 0", g);
      end
      $display("glitch %0d: 3-cycle high applied", g);
    end
    k = cyc;
    line = 1'b1;
    expect_pulse(k + 7);
    tick(4);
    line = 1'b0;
    tick(25);
    check_drained("glitch_4cyc");
    $display("4-cycle high at cycle %0d, one pulse expected at %0d", k, k + 7);
  endtask

  task automatic test_enable_high();
    int k;
    enable = 1'b0; line = 1'b1;
    tick(5);
    enable = 1'b1;
    tick(20);
    vectors++;
    if ({level_a, level_b} !== 2'b00) begin
      fails++;
      $display("FAIL enable_high level: got %b, required 00", {level_a, level_b});
    end
    line = 1'b0;
    tick(8);
    k = cyc;
    line = 1'b1;
    expect_pulse(k + 7);
    tick(20);
    vectors++;
    if ({level_a, level_b} !== 2'b11) begin
      fails++;
      $display("FAIL enable_high level after rise: got %b, required 11", {level_a, level_b});
    end
    check_drained("enable_high");
    $display("enable with line high: pulse only after re-rise at cycle %0d", k);
  endtask

  task automatic test_timeout();
    int k, c, m;
    enable = 1'b0; line = 1'b0;
    tick(2);
    k = cyc;
    enable = 1'b1;
    wait_cyc(k + 100);
    @(negedge clk);
    vectors++;
    if (to_a !== 1'b0) begin
      fails++;
      $display("FAIL timeout early: got %b at cycle %0d, required 0", to_a, cyc);
    end
    wait_cyc(k + 101);
    @(negedge clk);
    vectors++;
    if ({to_a, to_b} !== 2'b10) begin
      fails++;
      $display("FAIL timeout set: got %b at cycle %0d, required 10", {to_a, to_b}, cyc);
    end
    tick(1);
    c = cyc;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (to_a !== 1'b0) begin
      fails++;
      $display("FAIL timeout clear: got %b at cycle %0d, required 0", to_a, cyc);
    end
    tick(1);
    @(negedge clk);
    vectors++;
    if (to_a !== 1'b1) begin
      fails++;
      $display("FAIL timeout reset after clear: got %b at cycle %0d, required 1", to_a, cyc);
    end
    enable = 1'b0;
    tick(3);
    vectors++;
    if (to_a !== 1'b1) begin
      fails++;
      $display("FAIL timeout hold disabled: got %b, required 1", to_a);
    end
    enable = 1'b1;
    tick(5);
    m = cyc;
    line = 1'b1;
    expect_pulse(m + 7);
    wait_cyc(m + 7);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (to_a !== 1'b0) begin
      fails++;
      $display("FAIL timeout clear after edge: got %b, required 0", to_a);
    end
    tick(50);
    vectors++;
    if ({to_a, to_b} !== 2'b00) begin
      fails++;
      $display("FAIL timeout stays clear: got %b, required 00", {to_a, to_b});
    end
    check_drained("timeout");
    $display("timeout: set at cycle %0d, cleared at %0d, edge at %0d", k + 101, c + 1, m);
  endtask

  task automatic test_square();
    int r;
    enable = 1'b0; line = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(5);
    for (int i = 0; i < 5; i++) begin
      r = cyc;
      line = 1'b1;
      expect_pulse(r + 7);
`ifdef LINE_PERIOD_MEAS_EN
      if (i > 0) begin
        pqa.push_back('{c: r + 7, v: 100});
        pqb.push_back('{c: r + 7, v: 200});
      end
`endif
      tick(100);
      line = 1'b0;
      tick(100);
      $display("square wave rise %0d at cycle %0d", i, r);
    end
    tick(20);
    check_drained("square");
  endtask

  task automatic test_reset_mid();
    int k, m;
    enable = 1'b0; line = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(5);
    k = cyc;
    line = 1'b1;
    tick(4);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pulse_a, level_a, to_a, pulse_b, level_b, to_b} !== 6'b0) begin
      fails++;
      $display("FAIL async reset outputs: got %b, required 000000", {pulse_a, level_a, to_a, pulse_b, level_b, to_b});
    end
`ifdef LINE_PERIOD_MEAS_EN
    vectors++;
    if ({per_a, pv_a, per_b, pv_b} !== 42'b0) begin
      fails++;
      $display("FAIL async reset period: got %0d/%0d, required 0/0", per_a, per_b);
    end
`endif
    qa.delete(); qb.delete();
    tick(3);
    rst_n = 1'b1;
    tick(25);
    vectors++;
    if ({level_a, level_b} !== 2'b00) begin
      fails++;
      $display("FAIL reset release level: got %b, required 00", {level_a, level_b});
    end
    line = 1'b0;
    tick(8);
    m = cyc;
    line = 1'b1;
    expect_pulse(m + 7);
    tick(20);
    check_drained("reset_mid");
    $display("reset mid-qualification after rise at cycle %0d, re-rise at %0d", k, m);
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch();
    test_enable_high();
    test_timeout();
    test_square();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/line_cycle_detector.md
Name: line_cycle_detector

Overview:
- Upstream stage of the voltmeter cycle counter.
- Takes the asynchronous mains zero-cross comparator output and synchronises and debounces it.
- Emits exactly one single-cycle pulse per qualified rising edge (one line cycle); this pulse drives the cycle counter's increment input.
- Also flags loss of line: a sticky timeout when no cycle is seen within a bounded window.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronised samples required to accept a level change (legal 2..255).
- TIMEOUT_CYCLES, 65535, clk cycles without a pulse before timeout_o sets (legal 2..2^20-1).
- TO_W, 20, width of the timeout/period counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  detection enable, synchronous
- line_i  in  1  raw comparator output, asynchronous to clk_i
- timeout_clear_i  in  1  clears timeout_o, active high
- cycle_pulse_o  out  1  one-cycle pulse per qualified rising edge
- line_level_o  out  1  debounced line level
- timeout_o  out  1  sticky loss-of-line flag
- period_o  out  TO_W  last measured period in clk cycles (LINE_PERIOD_MEAS_EN only)
- period_valid_o  out  1  one-cycle strobe, period_o updated (LINE_PERIOD_MEAS_EN only)

Behaviour:
Reset and interface:
- Reset rst_n_i, asynchronous, active-low; clock clk_i.
- Reset values: all outputs 0, FSM = ARM, all counters 0, synchroniser flops 0.

Synchroniser and sample latency:
- line_i passes through a 2-flop synchroniser to give line_s.
- line_s reflects line_i two edges after line_i is first sampled.

FSM states: ARM, LOW, QUAL_HIGH, HIGH, QUAL_LOW.
- ARM: waits for line_s=0 → LOW. This prevents a spurious pulse when enabling with the line already high.
- LOW: line_s=1 → QUAL_HIGH with deb_cnt=1.
- QUAL_HIGH:
  - line_s=0 → LOW, deb_cnt=0.
  - line_s=1 and deb_cnt==DEBOUNCE_CYCLES-1 → HIGH.
  - otherwise deb_cnt+1.
- HIGH: line_s=0 → QUAL_LOW with deb_cnt=1.
- QUAL_LOW: mirror of QUAL_HIGH; exits to LOW on qualification, back to HIGH on a glitch.

Outputs:
- cycle_pulse_o is registered and is 1 only in the cycle after the QUAL_HIGH→HIGH transition.
- Total latency from the first edge sampling line_i=1 is DEBOUNCE_CYCLES+2 cycles.
- No pulse on a HIGH→LOW qualification.
- line_level_o is 1 in HIGH and QUAL_LOW, 0 otherwise.

enable_i:
- enable_i=0 forces FSM=ARM, deb_cnt=0, per_cnt=0, cycle_pulse_o=0 next cycle.
- timeout_o holds its value and cannot set while disabled.

Period/timeout counter (per_cnt):
- Increments every enabled cycle and saturates at TIMEOUT_CYCLES.
- Loads 0 in the cycle cycle_pulse_o asserts.
- timeout_o sets when per_cnt==TIMEOUT_CYCLES and stays set.
- timeout_clear_i clears timeout_o and wins over a same-cycle set.
- A clear with the condition still true lets timeout_o re-set the following cycle.

Reset mid-operation: any state returns immediately to the reset values; no pulse is emitted on reset exit.

Optional Feature:
- Macro LINE_PERIOD_MEAS_EN.
- Defined:
  - On each cycle_pulse_o, period_o <= per_cnt+1, saturated at TIMEOUT_CYCLES, and period_valid_o pulses in the same cycle.
  - The first pulse after ARM is not reported, so period_valid_o stays 0 for it.
  - Reset value of period_o and period_valid_o is 0.
- Undefined: period_o and period_valid_o ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package line_cycle_pkg holds:
  - FSM state encoding constants (ARM=0, LOW=1, QUAL_HIGH=2, HIGH=3, QUAL_LOW=4, 3 bits).
  - DEBOUNCE counter width (8).
  - Default TO_W.
- One sub-module, sync_2ff: a 2-flop synchroniser with async active-low reset, reusable elsewhere in the voltmeter.
- FSM and counters live in line_cycle_detector.

Test Plan:
- DEBOUNCE_CYCLES=4: reset, enable=1, line_i 0 for 10 cycles then held 1 → exactly one cycle_pulse_o, 6 cycles after the first sampling edge with line_i=1; line_level_o=1 from the same cycle.
- DEBOUNCE_CYCLES=4: line_i high pulses of 3 cycles, repeated → no cycle_pulse_o, line_level_o stays 0; a 4-cycle pulse yields exactly one pulse.
- Enable asserted while line_i=1 → no pulse until line_i falls (debounced) and rises again; then one pulse.
- TIMEOUT_CYCLES=100, line_i static → timeout_o rises after 100 enabled cycles.
  - timeout_clear_i pulse → timeout_o 0 for one cycle, then 1 again.
  - A valid line edge afterwards clears per_cnt, and timeout_o stays 0 once cleared.
- Square wave on line_i of period 200 clk cycles with LINE_PERIOD_MEAS_EN defined → period_valid_o on every pulse except the first, period_o=200.
- Assert rst_n_i low during QUAL_HIGH → all outputs 0 asynchronously, no pulse on release; FSM restarts in ARM.
